// File: rtl/sum_chain_pipe.sv
// sum_chain_pipe: two-stage registered x=a+b, y=a+b+x_prev with valid/ready on both sides.
module sum_chain_pipe #(
  parameter int W  = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  x,
  output logic [W-1:0]  y,
  output logic [CW-1:0] out_count
);
  logic          live_q;
  logic          s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  logic [W-1:0]  s1_a_q, s1_a_d, s1_b_q, s1_b_d, s1_x_q, s1_x_d, s1_xp_q, s1_xp_d;
  logic [W-1:0]  xp_q, xp_d, x_q, x_d, y_q, y_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          s1_adv, acc, s2_load, deliver;
  logic [W-1:0]  sum;
  // live_q holds in_ready low during reset and until the first edge after release
  always_comb begin
    s1_adv     = !s2_valid_q | out_ready;
    in_ready   = live_q & !clr & (!s1_valid_q | s1_adv);
    acc        = in_valid & in_ready;
    s2_load    = s1_valid_q & s1_adv;
    deliver    = s2_valid_q & out_ready;
    sum        = a + b;
    s1_valid_d = clr ? 1'b0 : acc ? 1'b1 : s1_adv ? 1'b0 : s1_valid_q;
    s2_valid_d = clr ? 1'b0 : s2_load ? 1'b1 : out_ready ? 1'b0 : s2_valid_q;
    xp_d       = clr ? '0 : acc ? sum : xp_q;
    cnt_d      = clr ? '0 : deliver ? cnt_q + 1'b1 : cnt_q;
    s1_a_d     = acc ? a : s1_a_q;
    s1_b_d     = acc ? b : s1_b_q;
    s1_x_d     = acc ? sum : s1_x_q;
    s1_xp_d    = acc ? xp_q : s1_xp_q;
    x_d        = s2_load ? s1_x_q : x_q;
    y_d        = s2_load ? s1_a_q + s1_b_q + s1_xp_q : y_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      live_q     <= 1'b0;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_x_q     <= '0;
      s1_xp_q    <= '0;
      xp_q       <= '0;
      x_q        <= '0;
      y_q        <= '0;
      cnt_q      <= '0;
    end else begin
      live_q     <= 1'b1;
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_x_q     <= s1_x_d;
      s1_xp_q    <= s1_xp_d;
      xp_q       <= xp_d;
      x_q        <= x_d;
      y_q        <= y_d;
      cnt_q      <= cnt_d;
    end
  end
  assign out_valid = s2_valid_q;
  assign x         = x_q;
  assign y         = y_q;
  assign out_count = cnt_q;
endmodule
